// File: rtl/debug_display_scanner_pkg.sv
// Shared constants for the debug seven-segment scanner: active-low hex
// glyphs {g,f,e,d,c,b,a}, the blank pattern and a width helper.
package debug_display_scanner_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    // Indexed by nibble value; entry 0 sits in the low bits.
    localparam logic [15:0][6:0] SEG_HEX = {
        SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
        SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
    };

    // Counter width that never collapses to zero bits for tiny ranges.
    function automatic int clog2_min1(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debug_display_scanner_hex_to_7seg.sv
// Combinational nibble to active-low seven-segment pattern decoder.
module hex_to_7seg
    import debug_display_scanner_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_HEX[nib_i];

endmodule

// File: rtl/debug_display_scanner.sv
// Multi-channel hex scanner: pages through debug words, can freeze a snapshot,
// blanks leading zeros and inserts dead time at the start of every digit slot.
module debug_display_scanner
    import debug_display_scanner_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int NUM_CHANNELS = 4,
    parameter int DATA_W       = 32,
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYC    = 1000
) (
    input  logic                              Clk,
    input  logic                              Reset,
    input  logic [NUM_CHANNELS*DATA_W-1:0]    ch_data,
    input  logic                              page_next,
    input  logic                              freeze,
    input  logic                              blank_lz,
    output logic [6:0]                        out7,
    output logic [NUM_DIGITS-1:0]             en_out,
    output logic [$clog2(NUM_CHANNELS)-1:0]   page_out
);

    localparam int DIG_W  = clog2_min1(NUM_DIGITS);
    localparam int PAGE_W = $clog2(NUM_CHANNELS);
    localparam int PRE_W  = clog2_min1(SCAN_DIV);
    localparam int WW     = NUM_DIGITS * 4;

    logic [PRE_W-1:0]               pre_q, pre_d;
    logic [DIG_W-1:0]               dig_q, dig_d;
    logic [PAGE_W-1:0]              page_q, page_d;
    logic                           pn_q, fz_q;
    logic [NUM_CHANNELS*DATA_W-1:0] snap_q, snap_d;
    logic [6:0]                     out7_q, out7_d;
    logic [NUM_DIGITS-1:0]          en_q, en_d;

    logic                           pn_rise, fz_rise, slot_end, lz;
    logic [DATA_W-1:0]              word;
    logic [WW-1:0]                  disp_w;
    logic [3:0]                     nib;
    logic [6:0]                     seg;

    always_comb begin
        pn_rise  = page_next & ~pn_q;
        fz_rise  = freeze & ~fz_q;
        slot_end = (pre_q == PRE_W'(SCAN_DIV - 1));

        pre_d = slot_end ? '0 : pre_q + 1'b1;

        dig_d = dig_q;
        if (slot_end)
            dig_d = (dig_q == DIG_W'(NUM_DIGITS - 1)) ? '0 : dig_q + 1'b1;

        page_d = page_q;
        if (pn_rise)
            page_d = (page_q == PAGE_W'(NUM_CHANNELS - 1)) ? '0 : page_q + 1'b1;

        snap_d = fz_rise ? ch_data : snap_q;
    end

    // In the capture cycle the bank is not loaded yet, but the live bus holds
    // exactly the words being captured, so showing it is equivalent.
    always_comb begin
        word = '0;
        if (freeze && !fz_rise)
            word = snap_q[page_q*DATA_W +: DATA_W];
        else
            word = ch_data[page_q*DATA_W +: DATA_W];
    end

    generate
        if (WW <= DATA_W) begin : g_trunc
            assign disp_w = word[WW-1:0];
        end else begin : g_zext
            assign disp_w = {{(WW-DATA_W){1'b0}}, word};
        end
    endgenerate

    assign nib = disp_w[dig_q*4 +: 4];

    hex_to_7seg u_hex (
        .nib_i (nib),
        .seg_o (seg)
    );

    // A digit is a leading zero when it and every more significant nibble are 0.
    always_comb begin
        lz     = blank_lz && (dig_q != '0) && ((disp_w >> (dig_q*4)) == '0);
        out7_d = lz ? SEG_BLANK : seg;
        en_d   = (pre_q < PRE_W'(BLANK_CYC)) ? '1
                                             : ~(NUM_DIGITS'(1) << dig_q);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pre_q  <= '0;
            dig_q  <= '0;
            page_q <= '0;
            pn_q   <= 1'b0;
            fz_q   <= 1'b0;
            snap_q <= '0;
            out7_q <= SEG_BLANK;
            en_q   <= '1;
        end else begin
            pre_q  <= pre_d;
            dig_q  <= dig_d;
            page_q <= page_d;
            pn_q   <= page_next;
            fz_q   <= freeze;
            snap_q <= snap_d;
            out7_q <= out7_d;
            en_q   <= en_d;
        end
    end

    assign out7     = out7_q;
    assign en_out   = en_q;
    assign page_out = page_q;

endmodule

// File: tb/tb_debug_display_scanner.sv
// Bench for debug_display_scanner at 4 digits / 4 channels / 16-bit words,
// SCAN_DIV=4, BLANK_CYC=1, with a cycle model feeding a scoreboard queue.
module tb_debug_display_scanner;

    localparam int ND = 4;
    localparam int NC = 4;
    localparam int DW = 16;
    localparam int SD = 4;
    localparam int BC = 1;

    logic          Clk;
    logic          Reset;
    logic [63:0]   ch_data;
    logic          page_next;
    logic          freeze;
    logic          blank_lz;
    logic [6:0]    out7;
    logic [3:0]    en_out;
    logic [1:0]    page_out;

    logic [15:0]   ch [4];
    assign ch_data = {ch[3], ch[2], ch[1], ch[0]};

    debug_display_scanner #(
        .NUM_DIGITS   (ND),
        .NUM_CHANNELS (NC),
        .DATA_W       (DW),
        .SCAN_DIV     (SD),
        .BLANK_CYC    (BC)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .ch_data   (ch_data),
        .page_next (page_next),
        .freeze    (freeze),
        .blank_lz  (blank_lz),
        .out7      (out7),
        .en_out    (en_out),
        .page_out  (page_out)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    typedef struct {
        logic [6:0] out7;
        logic [3:0] en;
        logic [1:0] page;
        bit         chk7;
    } exp_t;

    typedef struct {
        logic [3:0] en;
        logic [6:0] seg;
    } vec_t;

    logic [6:0] HEX7 [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    int          m_pre, m_dig, m_page;
    bit          m_pn, m_fz;
    logic [15:0] m_snap [4];
    int          last_pre, last_dig;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Predict the registered outputs for the coming edge, advance the model,
    // then compare after the edge.
    task automatic tick();
        exp_t        e;
        logic [15:0] w;
        logic [15:0] hi;
        bit          pr, fr;
        if (Reset) begin
            e = '{7'h7F, 4'hF, 2'd0, 1'b1};
            m_pre = 0; m_dig = 0; m_page = 0; m_pn = 0; m_fz = 0;
            for (int i = 0; i < 4; i++) m_snap[i] = '0;
            last_pre = -1; last_dig = -1;
        end else begin
            pr = page_next && !m_pn;
            fr = freeze && !m_fz;
            w  = (freeze && !fr) ? m_snap[m_page] : ch[m_page];
            hi = w >> (4 * m_dig);
            e.en   = (m_pre < BC) ? 4'hF : ~(4'b0001 << m_dig);
            e.out7 = (blank_lz && m_dig > 0 && hi == 16'h0) ? 7'h7F : HEX7[hi[3:0]];
            e.chk7 = (e.en != 4'hF);
            last_pre = m_pre; last_dig = m_dig;
            if (fr) for (int i = 0; i < 4; i++) m_snap[i] = ch[i];
            m_pn = page_next;
            m_fz = freeze;
            if (pr) m_page = (m_page + 1) % NC;
            if (m_pre == SD - 1) begin
                m_pre = 0;
                m_dig = (m_dig + 1) % ND;
            end else begin
                m_pre++;
            end
            e.page = 2'(m_page);
        end
        sbq.push_back(e);
        @(posedge Clk);
        #1;
        e = sbq.pop_front();
        chk("sb_en_out", 32'(en_out), 32'(e.en));
        chk("sb_page_out", 32'(page_out), 32'(e.page));
        if (e.chk7) chk("sb_out7", 32'(out7), 32'(e.out7));
    endtask

    task automatic pulse_page();
        page_next = 1'b1;
        tick();
        page_next = 1'b0;
        tick();
    endtask

    // Constant per-digit segment check, only on lit cycles.
    task automatic run_tbl(input string nm, input vec_t t[4], input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            if (last_pre < BC) begin
                chk({nm, "_blank_en"}, 32'(en_out), 32'hF);
            end else begin
                chk({nm, "_en"}, 32'(en_out), 32'(t[last_dig].en));
                chk({nm, "_seg"}, 32'(out7), 32'(t[last_dig].seg));
            end
        end
    endtask

    vec_t t2[4], t4[4], t4z[4], t5[4], t5z[4], t7[4];

    initial begin
        t2  = '{'{4'hE, 7'h00}, '{4'hD, 7'h08}, '{4'hB, 7'h24}, '{4'h7, 7'h79}};
        t4  = '{'{4'hE, 7'h40}, '{4'hD, 7'h0E}, '{4'hB, 7'h7F}, '{4'h7, 7'h7F}};
        t4z = '{'{4'hE, 7'h40}, '{4'hD, 7'h7F}, '{4'hB, 7'h7F}, '{4'h7, 7'h7F}};
        t5  = '{'{4'hE, 7'h0E}, '{4'hD, 7'h06}, '{4'hB, 7'h06}, '{4'h7, 7'h03}};
        t5z = '{'{4'hE, 7'h40}, '{4'hD, 7'h40}, '{4'hB, 7'h40}, '{4'h7, 7'h40}};
        t7  = '{'{4'hE, 7'h79}, '{4'hD, 7'h24}, '{4'hB, 7'h30}, '{4'h7, 7'h19}};

        Reset = 1'b1;
        page_next = 1'b0; freeze = 1'b0; blank_lz = 1'b0;
        for (int i = 0; i < 4; i++) ch[i] = '0;

        // Reset with random inputs
        for (int k = 0; k < 3; k++) begin
            page_next = 1'($urandom_range(0, 1));
            freeze    = 1'($urandom_range(0, 1));
            blank_lz  = 1'($urandom_range(0, 1));
            for (int i = 0; i < 4; i++) ch[i] = 16'($urandom);
            tick();
            chk("t1_out7", 32'(out7), 32'h7F);
            chk("t1_en", 32'(en_out), 32'hF);
            chk("t1_page", 32'(page_out), 32'h0);
        end

        // Basic scan of channel 0
        page_next = 0; freeze = 0; blank_lz = 0;
        ch[0] = 16'h12A8; ch[1] = 16'h3456; ch[2] = 16'h789A; ch[3] = 16'hBCDE;
        Reset = 1'b0;
        run_tbl("t2", t2, 20);

        // Paging: four single pulses, then a long hold
        for (int p = 1; p <= 4; p++) begin
            page_next = 1'b1;
            tick();
            chk("t3_page", 32'(page_out), 32'(p % 4));
            page_next = 1'b0;
            repeat (9) tick();
        end
        page_next = 1'b1;
        tick();
        chk("t3_hold_page", 32'(page_out), 32'h1);
        repeat (9) tick();
        chk("t3_hold_page_end", 32'(page_out), 32'h1);
        page_next = 1'b0;
        tick();

        // Leading-zero blanking on page 2
        pulse_page();
        chk("t4_page", 32'(page_out), 32'h2);
        ch[2] = 16'h00F0; blank_lz = 1'b1;
        run_tbl("t4", t4, 16);
        ch[2] = 16'h0000;
        run_tbl("t4z", t4z, 16);
        blank_lz = 1'b0;

        // Freeze snapshot on page 1
        pulse_page(); pulse_page(); pulse_page();
        chk("t5_page", 32'(page_out), 32'h1);
        ch[1] = 16'hBEEF;
        tick();
        freeze = 1'b1;
        tick();
        ch[1] = 16'h0000;
        run_tbl("t5", t5, 16);
        freeze = 1'b0;
        run_tbl("t5z", t5z, 8);

        // Freeze edge and page edge in the same cycle
        ch[2] = 16'h4321;
        freeze = 1'b1; page_next = 1'b1;
        tick();
        chk("t7_page", 32'(page_out), 32'h2);
        page_next = 1'b0;
        ch[2] = 16'h0000;
        run_tbl("t7", t7, 16);
        freeze = 1'b0;
        tick();

        // Random traffic against the model
        for (int k = 0; k < 300; k++) begin
            page_next = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 19) == 0) freeze = ~freeze;
            blank_lz = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
                for (int i = 0; i < 4; i++)
                    ch[i] = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            end
            tick();
        end
        page_next = 1'b0; freeze = 1'b0; blank_lz = 1'b0;
        tick();

        // Reset in the middle of digit 2's slot
        for (int i = 0; i < 40 && !(m_dig == 2 && m_pre == 2); i++) tick();
        chk("t6_reached_dig2", 32'(m_dig), 32'h2);
        Reset = 1'b1;
        tick();
        chk("t6_rst_en", 32'(en_out), 32'hF);
        chk("t6_rst_out7", 32'(out7), 32'h7F);
        chk("t6_rst_page", 32'(page_out), 32'h0);
        Reset = 1'b0;
        tick();
        chk("t6_first_blank", 32'(en_out), 32'hF);
        tick();
        chk("t6_first_lit", 32'(en_out), 32'hE);
        repeat (8) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
